// File: rtl/rv32i_fetch_stage_pkg.sv
// Shared types and default widths for the RV32I instruction fetch stage.
package rv32i_fetch_stage_pkg;
  localparam int          DEF_BW_ADDR  = 32;
  localparam int          DEF_BW_INST  = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INST_NOP     = 32'h0000_0013;

  typedef enum logic {
    S_BOOT  = 1'b0,
    S_FETCH = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/rv32i_sync_fifo.sv
// Generic synchronous FIFO with flush; head is visible combinationally, push and pop take effect at the clock edge.
// Push while full is accepted only together with a pop; flush wins over push/pop.
module rv32i_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head_dat,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             full, do_push, do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push != do_pop) count <= do_push ? count + (AW+1)'(1) : count - (AW+1)'(1);
    end
  end
endmodule

// File: rtl/rv32i_fetch_stage.sv
// RV32I fetch: credit-limited imem requests, in-order response buffering, redirect flush with stale-response discard.
// Response-to-decode latency 1 cycle; req drops when in-flight + buffered reaches BUF_DEPTH.
module rv32i_fetch_stage
  import rv32i_fetch_stage_pkg::*;
#(
  parameter int                 BW_ADDR   = DEF_BW_ADDR,
  parameter int                 BW_INST   = DEF_BW_INST,
  parameter logic [BW_ADDR-1:0] RESET_PC  = BW_ADDR'(DEF_RESET_PC),
  parameter int                 BUF_DEPTH = 2
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  output logic               o_imem_req,
  output logic [BW_ADDR-1:0] o_imem_addr,
  input  logic               i_imem_gnt,
  input  logic               i_imem_rvalid,
  input  logic [BW_INST-1:0] i_imem_rdata,
  input  logic               i_redirect,
  input  logic [BW_ADDR-1:0] i_redirect_pc,
  output logic               o_inst_valid,
  output logic [BW_INST-1:0] o_inst,
  output logic [BW_ADDR-1:0] o_inst_pc,
  input  logic               i_inst_ready
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam int EW = BW_ADDR + BW_INST;

  fetch_state_e       state_q, state_d;
  logic [BW_ADDR-1:0] fetch_pc_q;
  logic [CW-1:0]      discard_q, discard_d;
  logic [CW-1:0]      pcq_count, ibuf_count;
  logic [CW:0]        occupancy;
  logic               pcq_empty, ibuf_empty;
  logic [BW_ADDR-1:0] pcq_head;
  logic [EW-1:0]      ibuf_head;
  logic               fire, resp, keep, deq;
  logic               unused_redirect_lo;

  assign unused_redirect_lo = ^i_redirect_pc[1:0];

  // Credit covers every outstanding request, including ones already marked for discard.
  assign occupancy = {1'b0, pcq_count} + {1'b0, ibuf_count};

  always_comb begin
    state_d    = state_q;
    o_imem_req = 1'b0;
    case (state_q)
      S_BOOT:  state_d = S_FETCH;
      S_FETCH: o_imem_req = (occupancy < (CW+1)'(BUF_DEPTH));
    endcase
  end

  assign o_imem_addr = fetch_pc_q;
  assign fire        = o_imem_req & i_imem_gnt;
  assign resp        = i_imem_rvalid & ~pcq_empty;
  assign keep        = resp & (discard_q == '0) & ~i_redirect;
  assign deq         = o_inst_valid & i_inst_ready & ~i_redirect;

  // On redirect everything still outstanding after this edge belongs to the old stream.
  always_comb begin
    discard_d = discard_q;
    if (i_redirect) discard_d = pcq_count + CW'(fire) - CW'(resp);
    else if (resp && discard_q != '0) discard_d = discard_q - CW'(1);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= S_BOOT;
      fetch_pc_q <= RESET_PC;
      discard_q  <= '0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      if (i_redirect) fetch_pc_q <= {i_redirect_pc[BW_ADDR-1:2], 2'b00};
      else if (fire)  fetch_pc_q <= fetch_pc_q + BW_ADDR'(4);
    end
  end

  rv32i_sync_fifo #(.WIDTH(BW_ADDR), .DEPTH(BUF_DEPTH)) u_pc_queue (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .push     (fire),
    .push_dat (fetch_pc_q),
    .pop      (resp),
    .flush    (1'b0),
    .head_dat (pcq_head),
    .empty    (pcq_empty),
    .count    (pcq_count)
  );

  rv32i_sync_fifo #(.WIDTH(EW), .DEPTH(BUF_DEPTH)) u_inst_buf (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .push     (keep),
    .push_dat ({pcq_head, i_imem_rdata}),
    .pop      (deq),
    .flush    (i_redirect),
    .head_dat (ibuf_head),
    .empty    (ibuf_empty),
    .count    (ibuf_count)
  );

  assign o_inst_valid = ~ibuf_empty;
  assign o_inst_pc    = ibuf_head[EW-1:BW_INST];
  assign o_inst       = ibuf_head[BW_INST-1:0];
endmodule

// File: tb/tb_rv32i_fetch_stage.sv
// Randomised bench for rv32i_fetch_stage against a stream/epoch reference model and an in-order memory model.
module tb_rv32i_fetch_stage;
  localparam int DEPTH = 2;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt = 1'b0;
  logic        i_imem_rvalid = 1'b0;
  logic [31:0] i_imem_rdata = '0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        i_inst_ready = 1'b0;

  rv32i_fetch_stage #(.BUF_DEPTH(DEPTH)) dut (
    .i_clk         (i_clk),
    .i_rstn        (i_rstn),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_inst_valid  (o_inst_valid),
    .o_inst        (o_inst),
    .o_inst_pc     (o_inst_pc),
    .i_inst_ready  (i_inst_ready)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          rdy;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [31:0] buf_q[$];
  logic [31:0] iss_log[$];
  logic [31:0] out_log[$];
  logic [31:0] m_pc;
  int          m_epoch;
  bit          m_fetching;
  int          cyc, checks, errors, grants;
  int          p_gnt, p_rv, p_rdy, p_redir, p_err;
  bit          redir_now, redir_busy;
  logic [31:0] redir_val;
  logic        rstn_next;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mem_q.delete();
    buf_q.delete();
    m_pc       = 32'h0;
    m_epoch    = 0;
    m_fetching = 1'b0;
  endtask

  task automatic set_knobs(input int g, input int rv, input int rd, input int rdir);
    p_gnt = g; p_rv = rv; p_rdy = rd; p_redir = rdir;
  endtask

  task automatic clear_logs();
    iss_log.delete();
    out_log.delete();
    grants = 0;
  endtask

  task automatic drive();
    i_rstn        = rstn_next;
    i_imem_gnt    = ($urandom_range(99) < p_gnt);
    i_inst_ready  = ($urandom_range(99) < p_rdy);
    i_imem_rvalid = 1'b0;
    i_imem_rdata  = $urandom;
    if (mem_q.size() > 0) begin
      if (mem_q[0].rdy <= cyc && $urandom_range(99) < p_rv) begin
        i_imem_rvalid = 1'b1;
        i_imem_rdata  = mem_word(mem_q[0].addr);
      end
    end else if (i_rstn && $urandom_range(99) < p_err) begin
      i_imem_rvalid = 1'b1;
    end
    i_redirect    = 1'b0;
    i_redirect_pc = $urandom;
    if (redir_now) begin
      i_redirect    = 1'b1;
      i_redirect_pc = redir_val;
      redir_now     = 1'b0;
    end else if (redir_busy) begin
      if (o_imem_req && i_imem_gnt && i_imem_rvalid) begin
        i_redirect    = 1'b1;
        i_redirect_pc = redir_val;
        redir_busy    = 1'b0;
      end
    end else if ($urandom_range(99) < p_redir) begin
      i_redirect    = 1'b1;
      i_redirect_pc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15))
                                               : $urandom_range(32'h3FF);
    end
  endtask

  // Reference: requests follow a program-order PC; each redirect starts a new epoch and
  // any response from an older epoch (or arriving in the redirect cycle) never reaches decode.
  task automatic model_cycle();
    mreq_t e;
    bit    fire, pop, keep;
    int    occ;
    occ = mem_q.size() + buf_q.size();
    check("req", {31'b0, o_imem_req}, {31'b0, m_fetching && occ < DEPTH});
    check("addr", o_imem_addr, m_pc);
    check("valid", {31'b0, o_inst_valid}, {31'b0, buf_q.size() > 0});
    if (buf_q.size() > 0) begin
      check("inst_pc", o_inst_pc, buf_q[0]);
      check("inst", o_inst, mem_word(buf_q[0]));
    end
    fire = m_fetching && occ < DEPTH && i_imem_gnt;
    if (o_imem_req && i_imem_gnt) begin
      iss_log.push_back(o_imem_addr);
      grants++;
    end
    pop = (buf_q.size() > 0) && i_inst_ready && !i_redirect;
    if (pop) out_log.push_back(o_inst_pc);
    keep = 1'b0;
    if (i_imem_rvalid && mem_q.size() > 0) begin
      e    = mem_q.pop_front();
      keep = (e.epoch == m_epoch) && !i_redirect;
    end
    if (i_redirect) buf_q.delete();
    else begin
      if (pop) void'(buf_q.pop_front());
      if (keep) buf_q.push_back(e.addr);
    end
    if (fire) begin
      mem_q.push_back('{m_pc, m_epoch, cyc + 1});
      m_pc = m_pc + 32'd4;
    end
    if (i_redirect) begin
      m_epoch++;
      m_pc = {i_redirect_pc[31:2], 2'b00};
    end
    m_fetching = 1'b1;
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
    cyc++;
    drive();
    @(negedge i_clk);
    if (i_rstn) model_cycle();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, {31'b0, o_imem_req}, 32'h0);
    check({tag, "_addr"}, o_imem_addr, 32'h0);
    check({tag, "_valid"}, {31'b0, o_inst_valid}, 32'h0);
    check({tag, "_inst"}, o_inst, 32'h0);
    check({tag, "_pc"}, o_inst_pc, 32'h0);
  endtask

  // Reset asserted mid-cycle; outputs must go to reset values without waiting for a clock.
  task automatic do_reset(input string tag);
    @(posedge i_clk);
    #3;
    i_rstn        = 1'b0;
    rstn_next     = 1'b0;
    i_imem_rvalid = 1'b0;
    #1;
    check_reset_outputs(tag);
    model_reset();
    run(2);
    rstn_next = 1'b1;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; grants = 0;
    p_err = 0; redir_now = 1'b0; redir_busy = 1'b0; redir_val = '0;
    rstn_next = 1'b0;
    set_knobs(100, 100, 100, 0);
    model_reset();
    #12;
    check_reset_outputs("rst0");
    rstn_next = 1'b1;

    // Streaming with full grant / 1-cycle responses / ready
    clear_logs();
    run(30);
    check("t1_iss0", (iss_log.size() > 0) ? iss_log[0] : 32'hxxxx_xxxx, 32'h0);
    check("t1_iss1", (iss_log.size() > 1) ? iss_log[1] : 32'hxxxx_xxxx, 32'h4);
    check("t1_iss2", (iss_log.size() > 2) ? iss_log[2] : 32'hxxxx_xxxx, 32'h8);
    check("t1_out0", (out_log.size() > 0) ? out_log[0] : 32'hxxxx_xxxx, 32'h0);
    check("t1_out2", (out_log.size() > 2) ? out_log[2] : 32'hxxxx_xxxx, 32'h8);

    // Decode stalled: credit limits grants to BUF_DEPTH
    do_reset("rst1");
    clear_logs();
    set_knobs(100, 100, 0, 0);
    run(12);
    check("t2_grants", grants, DEPTH);
    check("t2_req", {31'b0, o_imem_req}, 32'h0);
    check("t2_hold_pc", o_inst_pc, 32'h0);
    set_knobs(100, 100, 100, 0);
    run(20);
    check("t2_out0", (out_log.size() > 0) ? out_log[0] : 32'hxxxx_xxxx, 32'h0);
    check("t2_out1", (out_log.size() > 1) ? out_log[1] : 32'hxxxx_xxxx, 32'h4);

    // Grant withheld: address must hold
    do_reset("rst2");
    clear_logs();
    set_knobs(0, 100, 100, 0);
    run(4);
    check("t3_addr", o_imem_addr, 32'h0);
    check("t3_grants", grants, 0);
    set_knobs(100, 100, 100, 0);
    run(3);
    check("t3_iss1", (iss_log.size() > 1) ? iss_log[1] : 32'hxxxx_xxxx, 32'h4);

    // Redirect with two requests in flight
    set_knobs(100, 0, 100, 0);
    run(4);
    redir_val = 32'h0000_0100;
    redir_now = 1'b1;
    set_knobs(100, 100, 100, 0);
    step();
    clear_logs();
    run(10);
    check("t4_iss0", (iss_log.size() > 0) ? iss_log[0] : 32'hxxxx_xxxx, 32'h100);
    check("t4_out0", (out_log.size() > 0) ? out_log[0] : 32'hxxxx_xxxx, 32'h100);
    begin
      int stale = 0;
      foreach (out_log[i]) if (out_log[i] < 32'h100) stale++;
      check("t4_stale", stale, 0);
    end

    // Misaligned redirect in the same cycle as a response and a grant
    redir_val  = 32'h0000_0203;
    redir_busy = 1'b1;
    for (int n = 0; n < 40 && redir_busy; n++) step();
    check("t5_fired", {31'b0, redir_busy}, 32'h0);
    redir_busy = 1'b0;
    clear_logs();
    run(8);
    check("t5_iss0", (iss_log.size() > 0) ? iss_log[0] : 32'hxxxx_xxxx, 32'h200);
    check("t5_out0", (out_log.size() > 0) ? out_log[0] : 32'hxxxx_xxxx, 32'h200);

    // Wrap at the top of the address space, then reset mid-stream
    redir_val = 32'hFFFF_FFFC;
    redir_now = 1'b1;
    step();
    clear_logs();
    run(8);
    check("t6_iss0", (iss_log.size() > 0) ? iss_log[0] : 32'hxxxx_xxxx, 32'hFFFF_FFFC);
    check("t6_iss1", (iss_log.size() > 1) ? iss_log[1] : 32'hxxxx_xxxx, 32'h0);
    check("t6_out1", (out_log.size() > 1) ? out_log[1] : 32'hxxxx_xxxx, 32'h0);
    do_reset("rst6");

    // Random traffic with redirects, stray responses and occasional resets
    for (int blk = 0; blk < 30; blk++) begin
      set_knobs($urandom_range(100, 30), $urandom_range(100, 30),
                $urandom_range(100, 20), $urandom_range(8, 0));
      p_err = $urandom_range(5, 0);
      run(100);
      if (blk % 10 == 9) do_reset("rstr");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
